// File: rtl/matvec_pkg.sv
// Shared types and sizing for the matrix-vector load sequencer.
package matvec_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    REQ,
    WAIT,
    UNPACK,
    RUN,
    FIN
  } state_t;

  function automatic int line_w(input int data_width, input int depth);
    return data_width * depth;
  endfunction

endpackage

// File: rtl/line_unpacker.sv
// Captures one memory line and presents it MSB element first, one element per advance.
module line_unpacker
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [DATA_WIDTH*DEPTH-1:0] line_data,
  input  logic                        advance,
  output logic [DATA_WIDTH-1:0]       elem,
  output logic                        last
);

  localparam int LINE_W = line_w(DATA_WIDTH, DEPTH);
  localparam int CW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LINE_W-1:0] line_q;
  logic [CW-1:0]     cnt;

  // Shifting left keeps the current element in the top slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      cnt    <= '0;
    end else if (load) begin
      line_q <= line_data;
      cnt    <= '0;
    end else if (advance) begin
      line_q <= line_q << DATA_WIDTH;
      cnt    <= last ? '0 : cnt + 1'b1;
    end
  end

  assign elem = line_q[LINE_W-1 -: DATA_WIDTH];
  assign last = (cnt == CW'(DEPTH - 1));

endmodule

// File: rtl/matvec_load_ctrl.sv
// Fetches DEPTH matrix rows plus the vector row and streams them into the MAC FIFOs.
//
// state  | meaning
// IDLE   | waiting for start; done holds the last job's completion
// CLR    | one-cycle MAC clear pulse
// REQ    | read request for line base+row, held through waitrequest
// WAIT   | waiting for readdatavalid; drain discards the line after abort
// UNPACK | DEPTH element writes to A FIFO[row] or, for row DEPTH, the B FIFO
// RUN    | waiting for mac_done
// FIN    | one cycle with done set before returning to IDLE
module matvec_load_ctrl
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [ADDR_W-1:0]           base_addr,
  output logic [ADDR_W-1:0]           mem_address,
  output logic                        mem_read,
  input  logic [DATA_WIDTH*DEPTH-1:0] mem_readdata,
  input  logic                        mem_readdatavalid,
  input  logic                        mem_waitrequest,
  output logic                        mac_clr,
  output logic [DEPTH-1:0]            a_wren,
  output logic [DATA_WIDTH-1:0]       a_data,
  output logic                        b_wren,
  output logic [DATA_WIDTH-1:0]       b_data,
  input  logic                        mac_done,
  output logic                        busy,
  output logic                        done
);

  localparam int RW = $clog2(DEPTH + 1);
  localparam logic [RW-1:0] ROW_B = RW'(DEPTH);

  state_t              state;
  logic [RW-1:0]       row;
  logic [ADDR_W-1:0]   base_q;
  logic                drain;
  logic                unp_load;
  logic                unp_adv;
  logic [DATA_WIDTH-1:0] elem;
  logic                elem_last;

  assign unp_load = (state == WAIT) && mem_readdatavalid && !drain && !abort;
  assign unp_adv  = (state == UNPACK);

  line_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (unp_load),
    .line_data (mem_readdata),
    .advance   (unp_adv),
    .elem      (elem),
    .last      (elem_last)
  );

  // Data lines are masked so idle FIFO inputs never toggle.
  assign a_data = (|a_wren) ? elem : '0;
  assign b_data = b_wren ? elem : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row         <= '0;
      base_q      <= '0;
      drain       <= 1'b0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      mac_clr     <= 1'b0;
      a_wren      <= '0;
      b_wren      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      mac_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            base_q  <= base_addr;
            done    <= 1'b0;
            busy    <= 1'b1;
            mac_clr <= 1'b1;
            drain   <= 1'b0;
            state   <= CLR;
          end
        end
        CLR: begin
          row <= '0;
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            mem_read    <= 1'b1;
            mem_address <= base_q;
            state       <= REQ;
          end
        end
        REQ: begin
          // An abort coinciding with acceptance must still drain the returning line.
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            drain    <= abort;
            state    <= WAIT;
          end else if (abort) begin
            mem_read <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        WAIT: begin
          if (mem_readdatavalid) begin
            if (drain || abort) begin
              drain <= 1'b0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              a_wren <= (row != ROW_B) ? (DEPTH'(1) << row) : '0;
              b_wren <= (row == ROW_B);
              state  <= UNPACK;
            end
          end else if (abort) begin
            drain <= 1'b1;
          end
        end
        UNPACK: begin
          if (abort) begin
            a_wren <= '0;
            b_wren <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (elem_last) begin
            a_wren <= '0;
            b_wren <= 1'b0;
            if (row == ROW_B) begin
              state <= RUN;
            end else begin
              row         <= row + 1'b1;
              mem_read    <= 1'b1;
              mem_address <= base_q + ADDR_W'(row) + ADDR_W'(1);
              state       <= REQ;
            end
          end
        end
        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
          end else if (mac_done) begin
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_load_ctrl.sv
// Scoreboard bench: memory slave model plus expected FIFO write stream for matvec_load_ctrl.
module tb_matvec_load_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int LW    = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          mac_done = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic [LW-1:0] mem_readdata = '0;
  logic          mem_readdatavalid = 1'b0;
  logic          mem_waitrequest = 1'b0;
  logic          mac_clr;
  logic [DEPTH-1:0] a_wren;
  logic [DW-1:0] a_data;
  logic          b_wren;
  logic [DW-1:0] b_data;
  logic          busy;
  logic          done;

  matvec_load_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
    .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
    .mac_clr(mac_clr), .a_wren(a_wren), .a_data(a_data), .b_wren(b_wren), .b_data(b_data),
    .mac_done(mac_done), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_b;
    int         row;
    logic [7:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] acc_q[$];
  logic [LW-1:0] mem [0:511];

  int checks = 0, errors = 0, cyc = 0;
  int clr_count = 0, clr_cycle = 0, last_wr_cycle = 0;
  int wr_a_count = 0, wr_b_count = 0;
  int fixed_lat = 1, lat_rand = 0;
  int stall_cnt = 0, watch_cnt = 0;
  logic [AW-1:0] stall_addr = '1, watch_addr = '1;

  always @(posedge clk) cyc++;

  // Memory slave: one outstanding read, configurable latency and stall.
  logic          pending = 1'b0, prev_wr = 1'b0;
  int            p_cnt = 0;
  logic [LW-1:0] p_data = '0;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0; prev_wr = 1'b0;
      mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
    end else begin
      mem_readdatavalid = 1'b0;
      mem_readdata = '0;
      if (pending) begin
        p_cnt--;
        if (p_cnt == 0) begin
          mem_readdatavalid = 1'b1; mem_readdata = p_data; pending = 1'b0;
        end
      end
      if (prev_wr) begin
        checks++;
        if (!(mem_read === 1'b1 && mem_address === prev_addr)) begin
          errors++;
          $display("FAIL stall_hold: read=%b addr=%h, required read=1 addr=%h", mem_read, mem_address, prev_addr);
        end
      end
      mem_waitrequest = (mem_read === 1'b1) && stall_cnt > 0 && mem_address == stall_addr;
      if (mem_waitrequest) stall_cnt--;
      prev_wr = mem_waitrequest;
      prev_addr = mem_address;
      if (mem_read === 1'b1 && !mem_waitrequest) begin
        checks++;
        if (pending) begin
          errors++;
          $display("FAIL outstanding: second read at %h while one pending, required at most one", mem_address);
        end
        acc_q.push_back(mem_address);
        pending = 1'b1;
        p_cnt = lat_rand != 0 ? int'($urandom_range(1, 7)) : fixed_lat;
        p_data = mem[mem_address[8:0]];
      end
    end
  end

  // Write monitor: pops the scoreboard on every FIFO write.
  int n_en;
  exp_t e;
  logic [25:0] got_v, exp_v;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mac_clr === 1'b1) begin clr_count++; clr_cycle = cyc; end
      if (mem_read === 1'b1 && mem_address == watch_addr) watch_cnt++;
      n_en = $countones({a_wren, b_wren});
      if (n_en > 1) begin
        checks++; errors++;
        $display("FAIL onehot: a_wren=%b b_wren=%b, required at most one enable", a_wren, b_wren);
      end else if (n_en == 1) begin
        checks++;
        got_v = {a_wren, a_data, b_wren, b_data};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: %h, required no write", got_v);
        end else begin
          e = exp_q.pop_front();
          exp_v = e.is_b ? {8'h00, 8'h00, 1'b1, e.data} : {8'(1 << e.row), e.data, 1'b0, 8'h00};
          if (got_v !== exp_v) begin
            errors++;
            $display("FAIL write_data: {a_wren,a_data,b_wren,b_data}=%h, required %h", got_v, exp_v);
          end
        end
        if (b_wren) wr_b_count++; else wr_a_count++;
        last_wr_cycle = cyc;
      end else if (a_data !== '0 || b_data !== '0) begin
        checks++; errors++;
        $display("FAIL idle_data: a_data=%h b_data=%h, required 0", a_data, b_data);
      end
    end
  end

  task automatic fill_rows(input int base, input bit rnd);
    for (int r = 0; r <= DEPTH; r++)
      mem[(base + r) & 511] = rnd ? {$urandom, $urandom} :
                             (r == DEPTH ? 64'h0102030405060708 : 64'h1122334455667788 + 64'(r));
  endtask

  task automatic push_rows(input int base, input int nrows);
    logic [LW-1:0] ln;
    exp_t x;
    for (int r = 0; r < nrows; r++) begin
      ln = mem[(base + r) & 511];
      for (int k = 0; k < DEPTH; k++) begin
        x.is_b = (r == DEPTH);
        x.row  = r;
        x.data = 8'(ln >> (LW - DW - k * DW));
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic start_job(input int base);
    @(negedge clk);
    base_addr = AW'(base);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes: %0d writes outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++; $display("FAIL %s_run: busy,done=%b, required 10", tag, {busy, done});
    end
    mac_done = 1'b1;
    @(negedge clk);
    mac_done = 1'b0;
    checks++;
    if ({busy, done} !== 2'b11) begin
      errors++; $display("FAIL %s_fin: busy,done=%b, required 11", tag, {busy, done});
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++; $display("FAIL %s_idle: busy,done=%b, required 01", tag, {busy, done});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s_sticky: done=%b, required 1", tag, done);
    end
  endtask

  task automatic check_addrs(input string tag, input int base);
    checks++;
    if (acc_q.size() != DEPTH + 1) begin
      errors++; $display("FAIL %s_nreq: %0d requests, required %0d", tag, acc_q.size(), DEPTH + 1);
    end else begin
      for (int i = 0; i <= DEPTH; i++) begin
        checks++;
        if (acc_q[i] !== AW'(base + i)) begin
          errors++; $display("FAIL %s_addr%0d: %h, required %h", tag, i, acc_q[i], AW'(base + i));
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_address, mem_read, mac_clr, a_wren, a_data, b_wren, b_data, busy, done} !== '0) begin
      errors++; $display("FAIL reset_outputs: addr=%h read=%b clr=%b aw=%b bw=%b busy=%b done=%b, required all 0",
                         mem_address, mem_read, mac_clr, a_wren, b_wren, busy, done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_read, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_idle: read,busy,done=%b, required 000", {mem_read, busy, done});
    end
  endtask

  task automatic test_basic;
    fill_rows(0, 0); fixed_lat = 1; lat_rand = 0;
    acc_q.delete(); clr_count = 0;
    push_rows(0, DEPTH + 1);
    start_job(0);
    run_to_done("basic");
    checks++;
    if (clr_count != 1) begin
      errors++; $display("FAIL basic_clr: %0d pulses, required 1", clr_count);
    end
    checks++;
    if (last_wr_cycle - clr_cycle != (DEPTH + 1) * (1 + 1 + DEPTH)) begin
      errors++; $display("FAIL basic_latency: last write %0d cycles after CLR, required %0d",
                         last_wr_cycle - clr_cycle, (DEPTH + 1) * (1 + 1 + DEPTH));
    end
    check_addrs("basic", 0);
  endtask

  task automatic test_stall;
    fill_rows(0, 0); fixed_lat = 1;
    acc_q.delete(); watch_cnt = 0; watch_addr = 3; stall_addr = 3; stall_cnt = 5;
    push_rows(0, DEPTH + 1);
    start_job(0);
    run_to_done("stall");
    checks++;
    if (watch_cnt != 6) begin
      errors++; $display("FAIL stall_cycles: read held %0d cycles at addr 3, required 6", watch_cnt);
    end
    check_addrs("stall", 0);
    watch_addr = '1; stall_addr = '1;
  endtask

  task automatic test_latency;
    fill_rows(32'h100, 1); lat_rand = 1;
    acc_q.delete(); wr_a_count = 0; wr_b_count = 0;
    push_rows(32'h100, DEPTH + 1);
    start_job(32'h100);
    run_to_done("latency");
    checks++;
    if (wr_a_count != DEPTH * DEPTH || wr_b_count != DEPTH) begin
      errors++; $display("FAIL latency_counts: A=%0d B=%0d, required A=%0d B=%0d",
                         wr_a_count, wr_b_count, DEPTH * DEPTH, DEPTH);
    end
    check_addrs("latency", 32'h100);
    lat_rand = 0;
  endtask

  task automatic test_abort_wait;
    int rd_seen;
    fill_rows(0, 0); fixed_lat = 4;
    acc_q.delete();
    push_rows(0, 5);
    start_job(0);
    for (int i = 0; i < 400 && acc_q.size() < 6; i++) @(negedge clk);
    checks++;
    if (acc_q.size() != 6) begin
      errors++; $display("FAIL abort_reach: %0d requests, required 6", acc_q.size());
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_drain: busy=%b while line outstanding, required 1", busy);
    end
    rd_seen = 0;
    for (int i = 0; i < 12 && busy !== 1'b0; i++) begin
      if (mem_read === 1'b1) rd_seen++;
      @(negedge clk);
    end
    checks++;
    if (rd_seen != 0) begin
      errors++; $display("FAIL abort_read: mem_read high %0d cycles, required 0", rd_seen);
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL abort_idle: busy,done=%b, required 00", {busy, done});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || acc_q.size() != 6) begin
      errors++; $display("FAIL abort_tail: pending writes=%0d requests=%0d, required 0 and 6",
                         exp_q.size(), acc_q.size());
    end
    exp_q.delete();
    fixed_lat = 1; acc_q.delete(); clr_count = 0;
    push_rows(0, DEPTH + 1);
    start_job(0);
    run_to_done("abort_restart");
    check_addrs("abort_restart", 0);
  endtask

  task automatic test_ignore;
    fill_rows(0, 0); fixed_lat = 2;
    acc_q.delete(); clr_count = 0; wr_a_count = 0;
    push_rows(0, DEPTH + 1);
    start_job(0);
    for (int i = 0; i < 400 && wr_a_count < 20; i++) @(negedge clk);
    base_addr = 32'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && mem_read !== 1'b1; i++) @(negedge clk);
    mac_done = 1'b1;
    @(negedge clk);
    mac_done = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10 || clr_count != 1) begin
      errors++; $display("FAIL ignore_stray: busy,done=%b clr=%0d, required 10 and 1", {busy, done}, clr_count);
    end
    run_to_done("ignore");
    check_addrs("ignore", 0);
  endtask

  task automatic test_reset_mid;
    fill_rows(0, 0); fixed_lat = 1;
    acc_q.delete(); wr_a_count = 0;
    push_rows(0, DEPTH + 1);
    start_job(0);
    for (int i = 0; i < 400 && wr_a_count < 3; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_address, mem_read, mac_clr, a_wren, a_data, b_wren, b_data, busy, done} !== '0) begin
      errors++; $display("FAIL reset_async: aw=%b ad=%h bw=%b busy=%b, required all 0", a_wren, a_data, b_wren, busy);
    end
    repeat (2) @(negedge clk);
    exp_q.delete(); acc_q.delete(); clr_count = 0;
    rst_n = 1'b1;
    push_rows(0, DEPTH + 1);
    start_job(0);
    run_to_done("reset_mid");
    check_addrs("reset_mid", 0);
    checks++;
    if (clr_count != 1) begin
      errors++; $display("FAIL reset_mid_clr: %0d pulses, required 1", clr_count);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_latency();
    test_abort_wait();
    test_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
